// File: rtl/dma_pkg.sv
// Shared definitions for the DMA request arbiter: FSM encoding, default channel count
// and the one-hot decode helper.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } dma_state_e;

  localparam int DMA_NCH_DEFAULT = 4;

  // Decodes up to 8 channels; callers size-cast the result down to NCH bits.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/dma_prio_enc.sv
// Combinational priority encoder: scans req upward from ptr (wrapping modulo NCH)
// and reports the first set index plus an any-request flag.
module dma_prio_enc
  import dma_pkg::*;
#(
  parameter int NCH = DMA_NCH_DEFAULT,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  winner,
  output logic           any
);

  always_comb begin
    int idx;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!any && req[idx]) begin
        winner = CW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// DMA request front end: masks device requests, grants one channel, routes DACK back and
// records terminal count. Define ROTATING_PRIO_EN for round-robin instead of fixed priority.
module dma_req_arbiter
  import dma_pkg::*;
#(
  parameter  int NCH = DMA_NCH_DEFAULT,
  localparam int CW  = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] DREQ_IN,
  input  logic           MASK_W,
  input  logic [NCH-1:0] MASK_IN,
  input  logic           STAT_CLR,
  input  logic           DACK,
  input  logic           EOP,
  output logic           DREQ,
  output logic [NCH-1:0] DACK_OUT,
  output logic [CW-1:0]  CH_SEL,
  output logic           CH_VALID,
  output logic [NCH-1:0] MASK,
  output logic [NCH-1:0] TC_STAT
);

  dma_state_e     state_reg, state_next;
  logic [CW-1:0]  ch_sel_reg, ch_sel_next;
  logic           ch_valid_reg, ch_valid_next;
  logic           dreq_reg, dreq_next;
  logic [NCH-1:0] mask_reg, mask_next;
  logic [NCH-1:0] tc_reg, tc_next;
  logic           eop_d_reg;
  logic [NCH-1:0] pending;
  logic           eop_rise;
  logic [CW-1:0]  win_idx;
  logic           win_any;
  logic [CW-1:0]  ptr_cur;

  assign pending  = DREQ_IN & ~mask_reg;
  assign eop_rise = EOP & ~eop_d_reg;

`ifdef ROTATING_PRIO_EN
  logic [CW-1:0] ptr_reg, ptr_next;
  assign ptr_cur = ptr_reg;
`else
  assign ptr_cur = '0;
`endif

  dma_prio_enc #(.NCH(NCH), .CW(CW)) u_prio_enc (
    .req    (pending),
    .ptr    (ptr_cur),
    .winner (win_idx),
    .any    (win_any)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      ch_sel_reg   <= '0;
      ch_valid_reg <= 1'b0;
      dreq_reg     <= 1'b0;
      mask_reg     <= '0;
      tc_reg       <= '0;
      eop_d_reg    <= 1'b0;
`ifdef ROTATING_PRIO_EN
      ptr_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      ch_sel_reg   <= ch_sel_next;
      ch_valid_reg <= ch_valid_next;
      dreq_reg     <= dreq_next;
      mask_reg     <= mask_next;
      tc_reg       <= tc_next;
      eop_d_reg    <= EOP;
`ifdef ROTATING_PRIO_EN
      ptr_reg      <= ptr_next;
`endif
    end
  end

  // Register writes and clears apply first so the FSM's auto-mask / TC set overrides them.
  always_comb begin
    state_next    = state_reg;
    ch_sel_next   = ch_sel_reg;
    ch_valid_next = ch_valid_reg;
    dreq_next     = dreq_reg;
    mask_next     = MASK_W ? MASK_IN : mask_reg;
    tc_next       = STAT_CLR ? '0 : tc_reg;
`ifdef ROTATING_PRIO_EN
    ptr_next      = ptr_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (win_any) begin
          ch_sel_next   = win_idx;
          ch_valid_next = 1'b1;
          dreq_next     = 1'b1;
          state_next    = ST_REQ;
`ifdef ROTATING_PRIO_EN
          ptr_next      = (win_idx == CW'(NCH - 1)) ? '0 : win_idx + CW'(1);
`endif
        end
      end
      ST_REQ: begin
        if (DACK) begin
          state_next = ST_ACTIVE;
        end else if (!pending[ch_sel_reg]) begin
          dreq_next     = 1'b0;
          ch_valid_next = 1'b0;
          state_next    = ST_RELEASE;
        end
      end
      ST_ACTIVE: begin
        dreq_next = pending[ch_sel_reg];
        if (eop_rise) begin
          tc_next[ch_sel_reg]   = 1'b1;
          mask_next[ch_sel_reg] = 1'b1;
          dreq_next             = 1'b0;
          ch_valid_next         = 1'b0;
          state_next            = ST_RELEASE;
        end else if (!DACK) begin
          if (pending[ch_sel_reg]) begin
            state_next = ST_REQ;
          end else begin
            dreq_next     = 1'b0;
            ch_valid_next = 1'b0;
            state_next    = ST_RELEASE;
          end
        end
      end
      default: begin
        dreq_next     = 1'b0;
        ch_valid_next = 1'b0;
        state_next    = ST_IDLE;
      end
    endcase
  end

  assign DREQ     = dreq_reg;
  assign CH_SEL   = ch_sel_reg;
  assign CH_VALID = ch_valid_reg;
  assign MASK     = mask_reg;
  assign TC_STAT  = tc_reg;
  assign DACK_OUT = NCH'(onehot8(3'(ch_sel_reg))) & {NCH{DACK & ch_valid_reg}};

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed self-checking bench for dma_req_arbiter (NCH=4); rotating-priority steps
// run only when ROTATING_PRIO_EN is defined.
module tb_dma_req_arbiter;

  logic       CLK;
  logic       RST;
  logic [3:0] DREQ_IN;
  logic       MASK_W;
  logic [3:0] MASK_IN;
  logic       STAT_CLR;
  logic       DACK;
  logic       EOP;
  logic       DREQ;
  logic [3:0] DACK_OUT;
  logic [1:0] CH_SEL;
  logic       CH_VALID;
  logic [3:0] MASK;
  logic [3:0] TC_STAT;

  int n_checks = 0;
  int n_fail   = 0;

  dma_req_arbiter #(.NCH(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DREQ_IN  (DREQ_IN),
    .MASK_W   (MASK_W),
    .MASK_IN  (MASK_IN),
    .STAT_CLR (STAT_CLR),
    .DACK     (DACK),
    .EOP      (EOP),
    .DREQ     (DREQ),
    .DACK_OUT (DACK_OUT),
    .CH_SEL   (CH_SEL),
    .CH_VALID (CH_VALID),
    .MASK     (MASK),
    .TC_STAT  (TC_STAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    RST = 1'b0; DREQ_IN = '0; MASK_W = 1'b0; MASK_IN = '0;
    STAT_CLR = 1'b0; DACK = 1'b0; EOP = 1'b0;
    tick(); tick();
    chk("rst_dreq", 8'(DREQ), 8'h0);
    chk("rst_chvalid", 8'(CH_VALID), 8'h0);
    chk("rst_chsel", 8'(CH_SEL), 8'h0);
    chk("rst_mask", 8'(MASK), 8'h0);
    chk("rst_tc", 8'(TC_STAT), 8'h0);
    chk("rst_dackout", 8'(DACK_OUT), 8'h0);
    @(negedge CLK); RST = 1'b1;
    #1;

    // 1: single request on ch2, DACK routed combinationally
    DREQ_IN = 4'b0100;
    tick();
    chk("t1_dreq", 8'(DREQ), 8'h1);
    chk("t1_chsel", 8'(CH_SEL), 8'h2);
    chk("t1_chvalid", 8'(CH_VALID), 8'h1);
    DACK = 1'b1;
    #1;
    chk("t1_dackout", 8'(DACK_OUT), 8'h04);
    tick();
    DREQ_IN = 4'b0000; DACK = 1'b0;
    #1;
    chk("t1_dackout_off", 8'(DACK_OUT), 8'h00);
    tick();
    chk("t1_rel_dreq", 8'(DREQ), 8'h0);
    chk("t1_rel_valid", 8'(CH_VALID), 8'h0);
    tick();

`ifndef ROTATING_PRIO_EN
    // 2: fixed priority ch1 over ch3, EOP auto-masks ch1
    DREQ_IN = 4'b1010;
    tick();
    chk("t2_chsel1", 8'(CH_SEL), 8'h1);
    DACK = 1'b1;
    tick();
    EOP = 1'b1;
    tick();
    chk("t2_tc", 8'(TC_STAT), 8'h02);
    chk("t2_mask", 8'(MASK), 8'h02);
    chk("t2_rel_valid", 8'(CH_VALID), 8'h0);
    EOP = 1'b0; DACK = 1'b0;
    tick();
    tick();
    chk("t2_chsel3", 8'(CH_SEL), 8'h3);
    chk("t2_valid3", 8'(CH_VALID), 8'h1);
    DREQ_IN = 4'b0000; MASK_W = 1'b1; MASK_IN = 4'b0000;
    tick();
    MASK_W = 1'b0;
    tick();
    chk("t2_mask_clr", 8'(MASK), 8'h00);
`else
    // 3: rotating priority with all channels requesting
    begin
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      RST = 1'b0; #1; RST = 1'b1;
      DREQ_IN = 4'b1111;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("t3_grant%0d", k), 8'(CH_SEL), 8'(exp_seq[k]));
        if (k < 4) begin
          DACK = 1'b1;
          tick();
          DACK = 1'b0;
          DREQ_IN[CH_SEL] = 1'b0;
          tick();
          DREQ_IN = 4'b1111;
          tick();
        end
      end
      DREQ_IN = 4'b0000;
      tick();
      tick();
    end
`endif

    // 4: request cancelled before DACK
    DREQ_IN = 4'b0001;
    tick();
    chk("t4_grant", 8'(CH_SEL), 8'h0);
    chk("t4_dreq", 8'(DREQ), 8'h1);
    DREQ_IN = 4'b0000;
    tick();
    chk("t4_cancel_dreq", 8'(DREQ), 8'h0);
    chk("t4_cancel_valid", 8'(CH_VALID), 8'h0);
    DREQ_IN = 4'b0001;
    tick();
    chk("t4_idle_valid", 8'(CH_VALID), 8'h0);
    tick();
    chk("t4_regrant", 8'(CH_VALID), 8'h1);
    DREQ_IN = 4'b0000;
    tick();
    tick();

    // 5: EOP level held for 5 edges sets TC once; STAT_CLR loses to a new set
    DREQ_IN = 4'b0001; STAT_CLR = 1'b1;
    tick();
    STAT_CLR = 1'b0;
    chk("t5_tc_clr", 8'(TC_STAT), 8'h00);
    DACK = 1'b1;
    tick();
    EOP = 1'b1;
    tick();
    chk("t5_tc_set", 8'(TC_STAT), 8'h01);
    DREQ_IN = 4'b0011;
    tick(); tick(); tick(); tick();
    chk("t5_tc_once", 8'(TC_STAT), 8'h01);
    chk("t5_ch1_active", 8'(CH_SEL), 8'h1);
    chk("t5_ch1_dreq", 8'(DREQ), 8'h1);
    EOP = 1'b0;
    tick();
    EOP = 1'b1; STAT_CLR = 1'b1;
    tick();
    chk("t5_set_wins", 8'(TC_STAT), 8'h02);
    chk("t5_mask", 8'(MASK), 8'h03);
    EOP = 1'b0; STAT_CLR = 1'b0; DACK = 1'b0; DREQ_IN = 4'b0000;
    MASK_W = 1'b1; MASK_IN = 4'b0000;
    tick();
    MASK_W = 1'b0;
    tick();

    // 6: async reset mid-ACTIVE
    DREQ_IN = 4'b0100;
    tick();
    DACK = 1'b1;
    tick();
    chk("t6_dackout", 8'(DACK_OUT), 8'h04);
    #1;
    RST = 1'b0;
    #1;
    chk("t6_rst_dreq", 8'(DREQ), 8'h0);
    chk("t6_rst_dackout", 8'(DACK_OUT), 8'h00);
    chk("t6_rst_valid", 8'(CH_VALID), 8'h0);
    DACK = 1'b0; DREQ_IN = 4'b0000;
    @(negedge CLK); RST = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
